conv_loop_data_out_32x32x128_16x16x512: RTL and testbench
=========================================================

# conv_loop_data_out_32x32x128_16x16x512

Output-side companion of the convolution loop data-in buffer. The data-in buffer replays the full input feature map once per output channel, so the convolution core emits one partial output map per (output channel, input channel) pair. This block accumulates those CHANNEL_NUM_IN partial maps in an internal buffer and emits one summed output map per output channel. The summed maps feed the next layer stage.

## Interface
- DATA_WIDTH, 32: sample width; signed two's-complement.
- IMAGE_WIDTH, 16: output map width/height; IMAGE_SIZE = IMAGE_WIDTH*IMAGE_WIDTH, which must be ≥ 2.
- CHANNEL_NUM_IN, 128: number of partial maps summed per output channel; must be ≥ 1.
- CHANNEL_NUM_OUT, 512: number of output channels per frame.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  pxl_in is valid this cycle.
- pxl_in  input  DATA_WIDTH  partial-sum sample; raster order within a map, maps in order ci = 0..CHANNEL_NUM_IN-1 for each co.
- pxl_out  output  DATA_WIDTH  accumulated sample; registered.
- valid_out  output  1  pxl_out is valid; registered.
- done  output  1  one-cycle pulse coincident with the last valid_out of the frame (co = CHANNEL_NUM_OUT-1, last pixel).

## Operation
- Counters (all advance only on valid_in = 1):
  - p: 0..IMAGE_SIZE-1. Wraps to 0 and increments ci.
  - ci: 0..CHANNEL_NUM_IN-1. Wraps to 0 and increments co.
  - co: 0..CHANNEL_NUM_OUT-1. Wraps to 0, and the next frame starts with no idle state.
- Internal buffer:
  - IMAGE_SIZE words × DATA_WIDTH, single port.
  - Synchronous read, 1-cycle read latency; synchronous write.
- Stage 1 (sampling edge, valid_in = 1):
  - Register pxl_in, p, and the flags first = (ci == 0) and last = (ci == CHANNEL_NUM_IN-1).
  - Present p as the read address.
- Stage 2 (next edge, for a valid stage-1 entry):
  - sum = (first ? 0 : buf[p]) + pxl_in_reg, truncated modulo 2^DATA_WIDTH with no saturation.
  - If not last: write sum to buf[p]; valid_out stays 0.
  - If last: pxl_out <= sum and valid_out <= 1. No write is required.
  - done <= last & (p == IMAGE_SIZE-1) & (co == CHANNEL_NUM_OUT-1).
- CHANNEL_NUM_IN = 1: first and last are both true, so the block is a pass-through with latency 2.
- Read/write hazard: none. The same address recurs only after IMAGE_SIZE ≥ 2 accepted samples, so a write always lands before that address is read again.
- No back-pressure:
  - Bubbles (valid_in = 0) are allowed anywhere and stall all counters.
  - Pipeline stages carry their own valid bits.
- pxl_out holds its last value while valid_out = 0.

## Timing
- Reset (asynchronous assert; deassertion is synchronous to clk):
  - p, ci and co are cleared.
  - Pipeline valid bits, valid_out, done and pxl_out are all cleared to 0.
- Buffer contents are not reset. The ci = 0 pass overwrites every word before it is read.
- Latency: valid_out/pxl_out are asserted on the 2nd rising edge after the edge that samples valid_in. This is constant and independent of bubbles.
- Throughput: 1 sample/cycle sustained. Output rate equals input rate during the last-ci map; otherwise no output.
- Reset mid-operation: in-flight samples are discarded. The first sample after reset is treated as co = 0, ci = 0, p = 0.
- Simultaneous wrap of p, ci and co on one sample: all three counters update on the same edge, and done fires 2 edges later with the matching valid_out.

## Test plan
Test parameters: IMAGE_WIDTH = 2 (IMAGE_SIZE = 4), CHANNEL_NUM_IN = 3, CHANNEL_NUM_OUT = 2.
- Basic sum:
  - Stimulus: ci0 = {1,2,3,4}, ci1 = {10,20,30,40}, ci2 = {100,200,300,400}, continuous valid_in.
  - Response: valid_out exactly 4 cycles, pxl_out = {111,222,333,444}, first output 2 edges after the first ci2 sample; no valid_out during ci0/ci1.
- Buffer re-initialisation:
  - Stimulus: second output channel with ci0 = {5,5,5,5}, ci1 = {0,0,0,0}, ci2 = {-1,-2,-3,-4}.
  - Response: pxl_out = {4,3,2,1}, showing no leftover from co = 0; done pulses with the output 1.
- Bubbles:
  - Stimulus: same data as "Basic sum", with valid_in deasserted for 3 cycles after every sample.
  - Response: identical output values; each valid_out occurs exactly 2 edges after its ci2 sample.
- Overflow:
  - Stimulus: ci0 = 0x7FFFFFFF, ci1 = 1, ci2 = 0 at p = 0.
  - Response: pxl_out = 0x80000000 (wrap, no saturation).
- Reset mid-frame:
  - Stimulus: assert reset asynchronously (between edges) during ci1; release; then send a full clean frame.
  - Response: outputs equal 0 immediately on assert; the clean frame produces correct sums and exactly one done.
- Pass-through:
  - Stimulus: CHANNEL_NUM_IN = 1, input {7,8,9,10}.
  - Response: pxl_out = {7,8,9,10} at latency 2; done on the last output of co = CHANNEL_NUM_OUT-1.

Source files
------------

// File: rtl/conv_loop_data_out_32x32x128_16x16x512.sv
// Output-side accumulator for the convolution loop.
// Sums CHANNEL_NUM_IN partial maps per output channel in an internal
// IMAGE_SIZE-word buffer and emits one summed map per output channel.
// Sampling edge captures the input and counters, the next edge reads the
// buffer at the captured address, and the edge after that forms the sum,
// so valid_out/pxl_out appear on the 2nd edge after valid_in is sampled.
module conv_loop_data_out_32x32x128_16x16x512 #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMAGE_WIDTH     = 16,
    parameter int CHANNEL_NUM_IN  = 128,
    parameter int CHANNEL_NUM_OUT = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  done
);

    localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_WIDTH;
    localparam int PW  = $clog2(IMAGE_SIZE);
    localparam int CIW = (CHANNEL_NUM_IN  > 1) ? $clog2(CHANNEL_NUM_IN)  : 1;
    localparam int COW = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;

    localparam logic [PW-1:0]  P_MAX  = PW'(IMAGE_SIZE - 1);
    localparam logic [CIW-1:0] CI_MAX = CIW'(CHANNEL_NUM_IN - 1);
    localparam logic [COW-1:0] CO_MAX = COW'(CHANNEL_NUM_OUT - 1);

    // Position counters
    logic [PW-1:0]  p_q,  p_d;
    logic [CIW-1:0] ci_q, ci_d;
    logic [COW-1:0] co_q, co_d;

    // Stage 1: captured sample and its position flags
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_pxl_q;
    logic [PW-1:0]         s1_p_q;
    logic                  s1_first_q;
    logic                  s1_last_q;
    logic                  s1_end_q;

    // Stage 2: sample waiting for the buffer read data
    logic                  s2_valid_q;
    logic [DATA_WIDTH-1:0] s2_pxl_q;
    logic [PW-1:0]         s2_p_q;
    logic                  s2_first_q;
    logic                  s2_last_q;
    logic                  s2_end_q;

    // Accumulation buffer (contents not reset; ci = 0 pass overwrites it)
    logic [DATA_WIDTH-1:0] mem_q [IMAGE_SIZE];
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] sum;

    // Output registers
    logic [DATA_WIDTH-1:0] pxl_out_q;
    logic                  valid_out_q;
    logic                  done_q;

    // Next-state of p/ci/co: advance on each accepted sample with nested wrap
    always_comb begin
        p_d  = p_q;
        ci_d = ci_q;
        co_d = co_q;
        if (valid_in) begin
            if (p_q == P_MAX) begin
                p_d = '0;
                if (ci_q == CI_MAX) begin
                    ci_d = '0;
                    co_d = (co_q == CO_MAX) ? '0 : co_q + COW'(1);
                end else begin
                    ci_d = ci_q + CIW'(1);
                end
            end else begin
                p_d = p_q + PW'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q  <= '0;
            ci_q <= '0;
            co_q <= '0;
        end else begin
            p_q  <= p_d;
            ci_q <= ci_d;
            co_q <= co_d;
        end
    end

    // Stage 1: capture sample, address and first/last/end-of-frame flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_pxl_q   <= '0;
            s1_p_q     <= '0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_end_q   <= 1'b0;
        end else begin
            s1_valid_q <= valid_in;
            if (valid_in) begin
                s1_pxl_q   <= pxl_in;
                s1_p_q     <= p_q;
                s1_first_q <= (ci_q == '0);
                s1_last_q  <= (ci_q == CI_MAX);
                s1_end_q   <= (ci_q == CI_MAX) && (p_q == P_MAX) && (co_q == CO_MAX);
            end
        end
    end

    // Stage 2: carry the sample alongside the buffer read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_pxl_q   <= '0;
            s2_p_q     <= '0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_end_q   <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_pxl_q   <= s1_pxl_q;
                s2_p_q     <= s1_p_q;
                s2_first_q <= s1_first_q;
                s2_last_q  <= s1_last_q;
                s2_end_q   <= s1_end_q;
            end
        end
    end

    // Partial sum; wraps modulo 2^DATA_WIDTH
    always_comb begin
        sum = (s2_first_q ? '0 : rd_q) + s2_pxl_q;
    end

    // Buffer: read at the stage-1 address, write back non-final partial sums.
    // Consecutive accepted samples have different addresses, so the write
    // for one sample never collides with the read of the next.
    always_ff @(posedge clk) begin
        if (s1_valid_q) begin
            rd_q <= mem_q[s1_p_q];
        end
        if (s2_valid_q && !s2_last_q) begin
            mem_q[s2_p_q] <= sum;
        end
    end

    // Output registers: emit the sum on the final input channel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pxl_out_q   <= '0;
            valid_out_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            valid_out_q <= s2_valid_q && s2_last_q;
            done_q      <= s2_valid_q && s2_end_q;
            if (s2_valid_q && s2_last_q) begin
                pxl_out_q <= sum;
            end
        end
    end

    assign pxl_out   = pxl_out_q;
    assign valid_out = valid_out_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_loop_data_out_32x32x128_16x16x512.sv
// Bench for conv_loop_data_out_32x32x128_16x16x512: a 3-input-channel
// instance and a 1-input-channel (pass-through) instance share one stimulus
// stream; outputs are compared every cycle against a positional model.
module tb_conv_loop_data_out_32x32x128_16x16x512;

    localparam int DW   = 32;
    localparam int IW   = 2;
    localparam int ISZ  = IW * IW;
    localparam int CIN  = 3;
    localparam int COUT = 2;
    localparam int FRM  = ISZ * CIN * COUT;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [DW-1:0] pxl_in;
    logic [DW-1:0] pxl_out, pt_pxl_out;
    logic          valid_out, pt_valid_out;
    logic          done, pt_done;

    always #5 clk = ~clk;

    conv_loop_data_out_32x32x128_16x16x512 #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
        .pxl_out(pxl_out), .valid_out(valid_out), .done(done)
    );

    conv_loop_data_out_32x32x128_16x16x512 #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .CHANNEL_NUM_IN(1), .CHANNEL_NUM_OUT(COUT)
    ) dut_pt (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
        .pxl_out(pt_pxl_out), .valid_out(pt_valid_out), .done(pt_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, expv);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Expectations are scheduled by edge number: a sample taken on edge k
    // is due on edge k+2.
    int            cyc = 0;
    bit            ev [int];
    logic [31:0]   epx[int];
    bit            ed [int];
    bit            pev[int];
    logic [31:0]   ppx[int];
    bit            ped[int];
    logic [31:0]   acc[ISZ];
    int unsigned   n;
    int            mp, mci, mco;
    logic [31:0]   last_px, pt_last_px;
    bit            cur_v, cur_d, pt_v, pt_d;
    logic [31:0]   mdl_log[$];

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            n = 0;
            last_px = '0; pt_last_px = '0;
            cur_v = 0; cur_d = 0; pt_v = 0; pt_d = 0;
            ev.delete(); epx.delete(); ed.delete();
            pev.delete(); ppx.delete(); ped.delete();
        end else begin
            cur_v = ev.exists(cyc);
            cur_d = cur_v ? ed[cyc] : 1'b0;
            if (cur_v) begin
                last_px = epx[cyc];
                mdl_log.push_back(last_px);
            end
            pt_v = pev.exists(cyc);
            pt_d = pt_v ? ped[cyc] : 1'b0;
            if (pt_v) pt_last_px = ppx[cyc];
            if (valid_in) begin
                mp  = int'(n % ISZ);
                mci = int'((n / ISZ) % CIN);
                mco = int'((n / (ISZ * CIN)) % COUT);
                if (mci == 0) acc[mp] = pxl_in;
                else          acc[mp] = acc[mp] + pxl_in;
                if (mci == CIN - 1) begin
                    ev[cyc + 2]  = 1'b1;
                    epx[cyc + 2] = acc[mp];
                    ed[cyc + 2]  = (mp == ISZ - 1) && (mco == COUT - 1);
                end
                pev[cyc + 2] = 1'b1;
                ppx[cyc + 2] = pxl_in;
                ped[cyc + 2] = (mp == ISZ - 1) && (((n / ISZ) % COUT) == COUT - 1);
                n++;
            end
        end
    end

    // ---------------- compare process ----------------
    logic [31:0] obs[$], pt_obs[$];
    int          done_cnt = 0, pt_done_cnt = 0;
    logic [31:0] done_px = '0;

    always @(negedge clk) begin
        if (reset) begin
            check("rst_valid_out", 32'(valid_out), 0);
            check("rst_pxl_out", pxl_out, 0);
            check("rst_done", 32'(done), 0);
            check("rst_pt_valid_out", 32'(pt_valid_out), 0);
        end else begin
            check("valid_out", 32'(valid_out), 32'(cur_v));
            check("pxl_out", pxl_out, last_px);
            check("done", 32'(done), 32'(cur_d));
            check("pt_valid_out", 32'(pt_valid_out), 32'(pt_v));
            check("pt_pxl_out", pt_pxl_out, pt_last_px);
            check("pt_done", 32'(pt_done), 32'(pt_d));
            if (valid_out) obs.push_back(pxl_out);
            if (done) begin
                done_cnt++;
                done_px = pxl_out;
            end
            if (pt_valid_out) pt_obs.push_back(pt_pxl_out);
            if (pt_done) pt_done_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] frm[FRM];
    logic [31:0] e_basic[8] = '{111, 222, 333, 444, 4, 3, 2, 1};
    logic [31:0] e_pt[4]    = '{7, 8, 9, 10};
    int base, mbase, pbase, d0, pd0;

    task automatic send(input logic [31:0] x, input int gaps);
        @(negedge clk);
        valid_in = 1'b1;
        pxl_in   = x;
        repeat (gaps) begin
            @(negedge clk);
            valid_in = 1'b0;
            pxl_in   = $urandom;
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            valid_in = 1'b0;
            pxl_in   = $urandom;
        end
    endtask

    // gapmode >= 0: fixed bubbles after each sample; < 0: random 0..2
    task automatic run_frame(input int gapmode);
        for (int i = 0; i < FRM; i++)
            send(frm[i], (gapmode >= 0) ? gapmode : int'($urandom_range(0, 2)));
    endtask

    task automatic rand_frame();
        for (int i = 0; i < FRM; i++) frm[i] = $urandom;
    endtask

    task automatic mark();
        base = obs.size(); mbase = mdl_log.size(); pbase = pt_obs.size();
        d0 = done_cnt; pd0 = pt_done_cnt;
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; pxl_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Basic sum (co = 0) then buffer re-initialisation (co = 1)
        frm = '{1, 2, 3, 4, 10, 20, 30, 40, 100, 200, 300, 400,
                5, 5, 5, 5, 0, 0, 0, 0,
                32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC};
        mark();
        run_frame(0);
        idle(4);
        check("basic_count", obs.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            check("basic_dut", obs[base + i], e_basic[i]);
            check("basic_model", mdl_log[mbase + i], e_basic[i]);
        end
        check("basic_done_count", done_cnt - d0, 1);
        check("basic_done_px", done_px, 1);
        check("basic_pt_count", pt_obs.size() - pbase, FRM);
        check("basic_pt_done_count", pt_done_cnt - pd0, 3);

        // Bubbles: three idle cycles after every sample
        frm[0:11] = '{1, 2, 3, 4, 10, 20, 30, 40, 100, 200, 300, 400};
        for (int i = 12; i < FRM; i++) frm[i] = $urandom;
        mark();
        run_frame(3);
        idle(4);
        for (int i = 0; i < 4; i++) check("bubble_dut", obs[base + i], e_basic[i]);
        check("bubble_done_count", done_cnt - d0, 1);

        // Overflow at p = 0 wraps without saturation
        rand_frame();
        frm[0] = 32'h7FFF_FFFF; frm[4] = 32'h1; frm[8] = 32'h0;
        mark();
        run_frame(0);
        idle(4);
        check("overflow_dut", obs[base], 32'h8000_0000);

        // Pass-through instance with leading {7,8,9,10}
        rand_frame();
        frm[0] = 7; frm[1] = 8; frm[2] = 9; frm[3] = 10;
        mark();
        run_frame(-1);
        idle(4);
        for (int i = 0; i < 4; i++) check("passthru_dut", pt_obs[pbase + i], e_pt[i]);
        check("passthru_done_count", pt_done_cnt - pd0, 3);

        // Reset asserted between edges during ci1, then a clean frame
        for (int i = 0; i < ISZ + 2; i++) send($urandom, 0);
        @(negedge clk);
        valid_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_rst_pxl_out", pxl_out, 0);
        check("async_rst_valid_out", 32'(valid_out), 0);
        check("async_rst_done", 32'(done), 0);
        check("async_rst_pt_pxl_out", pt_pxl_out, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rand_frame();
        mark();
        run_frame(0);
        idle(4);
        check("post_rst_count", obs.size() - base, 2 * ISZ);
        check("post_rst_done_count", done_cnt - d0, 1);

        // Random frames with random bubbles
        mark();
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            run_frame(-1);
        end
        idle(5);
        check("random_done_count", done_cnt - d0, 3);
        check("random_count", obs.size() - base, 3 * COUT * ISZ);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
